// File: rtl/core_muldiv_if.sv
// core_muldiv_if: request/result bundle between decode/register file and the
// iterative multiply/divide unit.
//   START, FUNCT3, RS1, RS2, RD_ADDR : request, driven by the master (decode)
//   BUSY, DONE, WADDR, WDATA, WE     : status and write-back, driven by the slave
interface core_muldiv_if;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic [4:0]  RD_ADDR;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  WADDR;
  logic [31:0] WDATA;
  logic        WE;

  modport master (
    output START, FUNCT3, RS1, RS2, RD_ADDR,
    input  BUSY, DONE, WADDR, WDATA, WE
  );

  modport slave (
    input  START, FUNCT3, RS1, RS2, RD_ADDR,
    output BUSY, DONE, WADDR, WDATA, WE
  );
endinterface

// File: rtl/core_muldiv.sv
// core_muldiv: iterative RV32M multiply/divide unit. Captures operands on
// START, runs a fixed 32-step shift-add multiply or restoring divide, and
// returns the result on the register-file write port. Fixed latency: DONE is
// high in the cycle after the 35th edge following the START edge.
//   CLK  : clock, rising edge
//   RST  : synchronous reset, active-high
//   bus  : core_muldiv_if.slave (request in, BUSY/DONE/WADDR/WDATA/WE out)
//
// state  | meaning
// IDLE   | waiting for START (ignored while DONE is still high)
// PREP   | take operand magnitudes, record result sign and special cases
// CALC   | 32 iterations, cnt_q 31..0
// FIX    | sign correction, result select, special-case override
// OUT    | register WDATA/WADDR, raise DONE (and WE unless rd is x0)
module core_muldiv (
  input  logic         CLK,
  input  logic         RST,
  core_muldiv_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_OUT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q, cnt_q, waddr_q;
  logic [31:0] a_orig_q, hi_q, lo_q, mcand_q, res_q, wdata_q;
  logic        neg_q, dz_q, ovf_q, done_q, we_q;

  logic        accept;
  logic        signed_a_op, signed_b_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_c, shift_c;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, result_c;

  // DONE cycle still counts as busy, so a START there is dropped.
  assign accept = (state == S_IDLE) && !done_q && bus.START;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_CALC;
      S_CALC:  if (cnt_q == 5'd0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    signed_a_op = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    signed_b_op = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    sign_a      = signed_a_op & lo_q[31];
    sign_b      = signed_b_op & mcand_q[31];
    mag_a       = sign_a ? -lo_q : lo_q;
    mag_b       = sign_b ? -mcand_q : mcand_q;
    // multiply: lo_q holds the multiplier and shifts product bits in from hi_q
    add_c       = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : 32'd0)};
    // divide: partial remainder is always < divisor, so the 33-bit shifted
    // value minus divisor fits in 32 bits whenever the subtract succeeds
    shift_c     = {hi_q, lo_q[31]};
    div_ge      = shift_c >= {1'b0, mcand_q};
    div_diff    = shift_c[31:0] - mcand_q;
    prod_fix    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix     = neg_q ? -lo_q : lo_q;
    rem_fix     = neg_q ? -hi_q : hi_q;
    result_c    = 32'd0;
    case (op_q)
      3'd0:             result_c = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: result_c = prod_fix[63:32];
      3'd4, 3'd5:       result_c = dz_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_fix);
      default:          result_c = dz_q ? a_orig_q : (ovf_q ? 32'd0 : rem_fix);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      cnt_q    <= 5'd0;
      a_orig_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      mcand_q  <= 32'd0;
      res_q    <= 32'd0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= bus.FUNCT3;
            lo_q     <= bus.RS1;
            mcand_q  <= bus.RS2;
            a_orig_q <= bus.RS1;
            rd_q     <= bus.RD_ADDR;
          end
        end
        S_PREP: begin
          hi_q  <= 32'd0;
          cnt_q <= 5'd31;
          // remainder takes the dividend's sign, everything else the xor
          neg_q <= (op_q[2] & op_q[1]) ? sign_a : (sign_a ^ sign_b);
          dz_q  <= op_q[2] & (mcand_q == 32'd0);
          ovf_q <= op_q[2] & ~op_q[0] & (lo_q == 32'h8000_0000) & (mcand_q == 32'hFFFF_FFFF);
          if (op_q[2]) begin
            lo_q    <= mag_a;
            mcand_q <= mag_b;
          end else begin
            lo_q    <= mag_b;
            mcand_q <= mag_a;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - 5'd1;
          if (op_q[2]) begin
            hi_q <= div_ge ? div_diff : shift_c[31:0];
            lo_q <= {lo_q[30:0], div_ge};
          end else begin
            hi_q <= add_c[32:1];
            lo_q <= {add_c[0], lo_q[31:1]};
          end
        end
        S_FIX: res_q <= result_c;
        S_OUT: begin
          wdata_q <= res_q;
          waddr_q <= rd_q;
          done_q  <= 1'b1;
          we_q    <= (rd_q != 5'd0);
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY  = (state != S_IDLE) || done_q;
  assign bus.DONE  = done_q;
  assign bus.WE    = we_q;
  assign bus.WADDR = waddr_q;
  assign bus.WDATA = wdata_q;
endmodule

// File: tb/tb_core_muldiv.sv
module tb_core_muldiv;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  core_muldiv_if bus();

  core_muldiv dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural RV32M result, computed with wide integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'd0;
    p   = 64'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0)  r = 32'hFFFF_FFFF;
        else if (ovf)    r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0)  r = a;
        else if (ovf)    r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Timeline model: accepted op completes 35 edges after its START edge.
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_we = 1'b0;
  bit          m_was_busy;
  int          m_age = 0;
  logic [4:0]  m_rd = 5'd0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_wdata = 32'd0;

  always @(posedge CLK) begin
    if (RST) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_we     = 1'b0;
      m_waddr  = 5'd0;
      m_wdata  = 32'd0;
    end else begin
      m_was_busy = m_active || m_done;
      m_done = 1'b0;
      m_we   = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == 35) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_we     = (m_rd != 5'd0);
          m_waddr  = m_rd;
          m_wdata  = m_res;
        end
      end else if (!m_was_busy && bus.START) begin
        m_active = 1'b1;
        m_age    = 0;
        m_rd     = bus.RD_ADDR;
        m_res    = ref_res(bus.FUNCT3, bus.RS1, bus.RS2);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy",  32'(bus.BUSY),  32'(m_active || m_done));
      chk("done",  32'(bus.DONE),  32'(m_done));
      chk("we",    32'(bus.WE),    32'(m_we));
      chk("waddr", 32'(bus.WADDR), 32'(m_waddr));
      chk("wdata", bus.WDATA, m_wdata);
    end
  end

  // mode: 0 plain, 1 extra START at E0+10, 2 reset at E0+12, 3 START in DONE cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int mode);
    int lat;
    bit seen;
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.FUNCT3 = f; bus.RS1 = a; bus.RS2 = b; bus.RD_ADDR = rd;
    @(posedge CLK); #1;
    bus.START   = 1'b0;
    bus.FUNCT3  = 3'($urandom_range(7, 0));
    bus.RS1     = $urandom;
    bus.RS2     = $urandom;
    bus.RD_ADDR = 5'($urandom_range(31, 0));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge CLK);
      if (bus.DONE) seen = 1'b1;
      else begin
        if (mode == 1 && lat == 9) begin
          bus.START = 1'b1; bus.FUNCT3 = 3'd0; bus.RS1 = 32'd3; bus.RS2 = 32'd3;
          bus.RD_ADDR = 5'd17;
        end
        if (mode == 1 && lat == 10) bus.START = 1'b0;
        if (mode == 2 && lat == 11) RST = 1'b1;
        if (mode == 2 && lat == 12) begin
          chk("abort_busy", 32'(bus.BUSY), 32'd0);
          chk("abort_wdata", bus.WDATA, 32'd0);
          RST = 1'b0;
        end
        @(posedge CLK); #1;
        lat++;
      end
    end
    if (mode == 2) begin
      chk("abort_no_done", 32'(seen), 32'd0);
    end else begin
      chk("done_seen", 32'(seen), 32'd1);
      if (seen) begin
        chk("latency", 32'(lat), 32'd35);
        chk("result", bus.WDATA, exp);
        chk("result_addr", 32'(bus.WADDR), 32'(rd));
        chk("result_we", 32'(bus.WE), 32'(rd != 5'd0));
        if (mode == 3) begin
          bus.START = 1'b1; bus.FUNCT3 = 3'd5; bus.RS1 = 32'd9; bus.RS2 = 32'd2;
          bus.RD_ADDR = 5'd4;
        end
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(5, 0))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(20, 0));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bus.START = 1'b0; bus.FUNCT3 = 3'd0; bus.RS1 = 32'd0; bus.RS2 = 32'd0; bus.RD_ADDR = 5'd0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_wdata", bus.WDATA, 32'd0);

    chk("model_mul",    ref_res(3'd0, 32'd7, 32'd6), 32'h0000_002A);
    chk("model_mulh",   ref_res(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model_mulhu",  ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("model_div",    ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem",    ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_divu",   ref_res(3'd5, 32'd100, 32'd7), 32'd14);
    chk("model_remu",   ref_res(3'd7, 32'd100, 32'd7), 32'd2);
    chk("model_div0",   ref_res(3'd4, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("model_remu0",  ref_res(3'd7, 32'd5, 32'd0), 32'd5);
    chk("model_ovf_q",  ref_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("model_ovf_r",  ref_res(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 0);
    repeat (3) @(negedge CLK);
    chk("hold_wdata", bus.WDATA, 32'h0000_002A);
    chk("hold_waddr", 32'(bus.WADDR), 32'd5);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 3);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 0);
    run_op(3'd4, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd5, 32'd0, 5'd13, 32'd5, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 0);
    run_op(3'd0, 32'd7, 32'd6, 5'd16, 32'h0000_002A, 1);
    run_op(3'd5, 32'd100, 32'd7, 5'd0, 32'd14, 0);
    run_op(3'd0, 32'd1234, 32'd5678, 5'd20, 32'd0, 2);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'h0000_0001, 0);

    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(7, 0));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(31, 0));
      run_op(f, a, b, rd, ref_res(f, a, b), ($urandom_range(4, 0) == 0) ? 1 : 0);
    end

    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
